// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: stall vector encoding,
// exception descriptor, PC redirect and controller state.
package pipe_ctrl_pkg;

    typedef logic reset_status_t;
    localparam reset_status_t RST_ENABLE = 1'b1;

    typedef logic [31:0] inst_addr_t;

    typedef struct packed {
        logic       en;
        inst_addr_t addr;
    } jump_t;

    // bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
    typedef logic [5:0] stall_t;

    typedef struct packed {
        logic       valid;
        logic       is_eret;
        logic [4:0] code;
    } excp_t;

    typedef enum logic {
        CTRL_RUN,
        CTRL_RECOVER
    } ctrl_state_t;

    localparam stall_t STALL_NONE     = 6'b000000;
    localparam stall_t STALL_FROM_IF  = 6'b000011;
    localparam stall_t STALL_FROM_ID  = 6'b000111;
    localparam stall_t STALL_FROM_EX  = 6'b001111;
    localparam stall_t STALL_FROM_MEM = 6'b011111;

    localparam inst_addr_t EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    // The deepest requester wins: freezing a later stage freezes everything upstream.
    function automatic stall_t encode_stall(input logic req_if, input logic req_id,
                                            input logic req_ex, input logic req_mem);
        if (req_mem)     return STALL_FROM_MEM;
        else if (req_ex) return STALL_FROM_EX;
        else if (req_id) return STALL_FROM_ID;
        else if (req_if) return STALL_FROM_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// Consecutive-stall watchdog: counts back-to-back stalled cycles and raises a
// sticky timeout flag once the count reaches WDOG_LIMIT.
module stall_watchdog #(
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    output logic stall_timeout
);
    import pipe_ctrl_pkg::*;

    localparam int unsigned CNT_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(WDOG_LIMIT - 1);

    logic [CNT_W-1:0] run_cnt;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            run_cnt       <= '0;
            stall_timeout <= 1'b0;
        end else begin
            if (!stall_active)
                run_cnt <= '0;
            else if (run_cnt != LIMIT)
                run_cnt <= run_cnt + 1'b1;

            // This edge closes the WDOG_LIMIT-th consecutive stalled cycle.
            if (stall_active && run_cnt == LIMIT_M1)
                stall_timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests, sequences exception
// and ERET flushes with a masked recovery window, and tracks stall statistics.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter inst_addr_t  EXC_VECTOR     = EXC_VECTOR_DEFAULT,
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned WDOG_LIMIT     = 1024
) (
    input  logic          clk,
    input  reset_status_t rst,
    input  logic          stallreq_if,
    input  logic          stallreq_id,
    input  logic          stallreq_ex,
    input  logic          stallreq_mem,
    input  excp_t         mem_excp,
    input  inst_addr_t    cp0_epc,
    output stall_t        stall,
    output logic          flush,
    output jump_t         redirect,
    output logic [31:0]   stall_cycles,
    output logic          stall_timeout
);

    localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

    ctrl_state_t state, state_next;
    logic [3:0]  recover_cnt, recover_cnt_next;

    // The exception code is consumed by CP0, not by the flush sequencing.
    logic unused_code;
    assign unused_code = &{1'b0, mem_excp.code};

    // NOTE: every output and next-state signal gets a default before the case
    // so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        stall            = encode_stall(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        flush            = 1'b0;
        redirect         = '0;
        state_next       = state;
        recover_cnt_next = recover_cnt;

        case (state)
            CTRL_RUN: begin
                if (mem_excp.valid) begin
                    // The exception drops any concurrent stall request.
                    stall            = STALL_NONE;
                    flush            = 1'b1;
                    redirect.en      = 1'b1;
                    redirect.addr    = mem_excp.is_eret ? cp0_epc : EXC_VECTOR;
                    state_next       = CTRL_RECOVER;
                    recover_cnt_next = RECOVER_LOAD;
                end
            end
            CTRL_RECOVER: begin
                if (recover_cnt == 4'd0)
                    state_next = CTRL_RUN;
                else
                    recover_cnt_next = recover_cnt - 4'd1;
            end
            default: state_next = CTRL_RUN;
        endcase

        if (rst == RST_ENABLE) begin
            stall    = STALL_NONE;
            flush    = 1'b0;
            redirect = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state        <= CTRL_RUN;
            recover_cnt  <= '0;
            stall_cycles <= '0;
        end else begin
            state       <= state_next;
            recover_cnt <= recover_cnt_next;
            if (stall != STALL_NONE && !flush && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end

    stall_watchdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_watchdog (
        .clk           (clk),
        .rst           (rst),
        .stall_active  (stall != STALL_NONE),
        .stall_timeout (stall_timeout)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven per-cycle vectors checked
// through an expectation queue, plus hand sequences for the multi-cycle cases.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic          clk = 1'b0;
    reset_status_t rst;
    logic          stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    excp_t         mem_excp;
    inst_addr_t    cp0_epc;
    stall_t        stall;
    logic          flush;
    jump_t         redirect;
    logic [31:0]   stall_cycles;
    logic          stall_timeout;

    pipe_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .mem_excp      (mem_excp),
        .cp0_epc       (cp0_epc),
        .stall         (stall),
        .flush         (flush),
        .redirect      (redirect),
        .stall_cycles  (stall_cycles),
        .stall_timeout (stall_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;      // {mem, ex, id, if}
        logic       valid;
        logic       eret;
        inst_addr_t epc;
        stall_t     exp_stall;
        logic       exp_flush;
        jump_t      exp_redir;
    } vec_t;

    typedef struct packed {
        stall_t stall;
        logic   flush;
        jump_t  redir;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_cycles = 0;

    localparam inst_addr_t EPC_A = 32'h8000_0100;
    localparam inst_addr_t VEC   = 32'hBFC0_0380;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req)
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        else
            n_pass++;
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] req, input logic v,
                                input logic e, input inst_addr_t epc, input stall_t s,
                                input logic f, input logic ren, input inst_addr_t raddr);
        vec_t t;
        t.rst = r; t.req = req; t.valid = v; t.eret = e; t.epc = epc;
        t.exp_stall = s; t.exp_flush = f; t.exp_redir = '{en: ren, addr: raddr};
        return t;
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        rst          = v.rst;
        stallreq_mem = v.req[3];
        stallreq_ex  = v.req[2];
        stallreq_id  = v.req[1];
        stallreq_if  = v.req[0];
        mem_excp     = '{valid: v.valid, is_eret: v.eret, code: 5'h04};
        cp0_epc      = v.epc;
        e.stall = v.exp_stall; e.flush = v.exp_flush; e.redir = v.exp_redir;
        exp_q.push_back(e);
        if (v.rst)
            exp_cycles = 0;
        else if (v.exp_stall != 6'b0 && !v.exp_flush && exp_cycles != 32'hFFFF_FFFF)
            exp_cycles++;
    endtask

    task automatic sample(input string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check({name, "_stall"}, 64'(stall), 64'(e.stall));
        check({name, "_flush"}, 64'(flush), 64'(e.flush));
        check({name, "_redir"}, 64'(redirect), 64'(e.redir));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input vec_t v, input string name);
        next_cycle();
        drive(v);
        @(negedge clk);
        sample(name);
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    vec_t tbl[14];

    initial begin
        // Stall priority table, test-plan sequence first.
        tbl[0]  = mk(0, 4'b0110, 0, 0, 0, 6'b001111, 0, 0, 0);
        tbl[1]  = mk(0, 4'b0010, 0, 0, 0, 6'b000111, 0, 0, 0);
        tbl[2]  = mk(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 0, 0);
        tbl[3]  = mk(0, 4'b0001, 0, 0, 0, 6'b000011, 0, 0, 0);
        tbl[4]  = mk(0, 4'b0100, 0, 0, 0, 6'b001111, 0, 0, 0);
        tbl[5]  = mk(0, 4'b1000, 0, 0, 0, 6'b011111, 0, 0, 0);
        tbl[6]  = mk(0, 4'b1001, 0, 0, 0, 6'b011111, 0, 0, 0);
        tbl[7]  = mk(0, 4'b0011, 0, 0, 0, 6'b000111, 0, 0, 0);
        tbl[8]  = mk(0, 4'b1111, 0, 0, 0, 6'b011111, 0, 0, 0);
        tbl[9]  = mk(0, 4'b0101, 0, 0, 0, 6'b001111, 0, 0, 0);
        tbl[10] = mk(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 0, 0);
        tbl[11] = mk(0, 4'b1010, 0, 0, 0, 6'b011111, 0, 0, 0);
        tbl[12] = mk(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 0, 0);
        tbl[13] = mk(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 0, 0);

        // Reset with live requests: outputs must be forced quiet.
        rst = 1'b1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 1;
        mem_excp = '{valid: 1'b1, is_eret: 1'b0, code: 5'h04}; cp0_epc = EPC_A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_flush", 64'(flush), 64'd0);
        check("rst_redir", 64'(redirect), 64'd0);
        check("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        check("rst_timeout", 64'(stall_timeout), 64'd0);

        for (int i = 0; i < 14; i++) begin
            if (i == 3) begin
                next_cycle();
                check("t1_stall_cycles", 64'(stall_cycles), 64'd2);
                drive(tbl[i]);
                @(negedge clk);
                sample($sformatf("vec%0d", i));
            end else begin
                step(tbl[i], $sformatf("vec%0d", i));
            end
        end

        // Exception with concurrent MEM stall, then masked recovery window.
        step(mk(0, 4'b1000, 1, 0, 0, 6'b000000, 1, 1, VEC), "exc_take");
        step(mk(0, 4'b1000, 1, 0, 0, 6'b011111, 0, 0, 0),   "exc_rec1");
        step(mk(0, 4'b1000, 1, 0, 0, 6'b011111, 0, 0, 0),   "exc_rec_last");
        step(mk(0, 4'b1000, 1, 0, 0, 6'b000000, 1, 1, VEC), "exc_back_run");
        step(mk(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 0, 0),   "exc_idle1");
        step(mk(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 0, 0),   "exc_idle2");

        // ERET redirects to EPC and flushes exactly once.
        step(mk(0, 4'b0000, 1, 1, EPC_A, 6'b000000, 1, 1, EPC_A), "eret_take");
        step(mk(0, 4'b0000, 1, 1, EPC_A, 6'b000000, 0, 0, 0),     "eret_rec1");
        step(mk(0, 4'b0000, 1, 1, EPC_A, 6'b000000, 0, 0, 0),     "eret_rec2");
        step(mk(0, 4'b0000, 0, 0, 0,     6'b000000, 0, 0, 0),     "eret_idle");

        // Reset in the first RECOVER cycle abandons the window.
        step(mk(0, 4'b0000, 1, 0, 0, 6'b000000, 1, 1, VEC), "rr_take");
        step(mk(1, 4'b1000, 1, 0, 0, 6'b000000, 0, 0, 0),   "rr_in_reset");
        next_cycle();
        check("rr_stall_cycles", 64'(stall_cycles), 64'd0);
        check("rr_timeout", 64'(stall_timeout), 64'd0);
        drive(mk(0, 4'b0000, 1, 0, 0, 6'b000000, 1, 1, VEC));
        @(negedge clk);
        sample("rr_exc_after_reset");
        step(mk(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 0, 0), "rr_idle1");
        step(mk(0, 4'b0000, 0, 0, 0, 6'b000000, 0, 0, 0), "rr_idle2");
        next_cycle();
        check("model_stall_cycles", 64'(stall_cycles), 64'(exp_cycles));

        // Watchdog: 1024 consecutive stalled cycles.
        stallreq_mem = 1'b1;
        mem_excp     = '0;
        for (int k = 0; k < 1023; k++) next_cycle();
        check("wdog_before_limit", 64'(stall_timeout), 64'd0);
        next_cycle();
        check("wdog_at_limit", 64'(stall_timeout), 64'd1);
        stallreq_mem = 1'b0;
        exp_cycles   = exp_cycles + 32'd1024;
        repeat (3) next_cycle();
        check("wdog_sticky", 64'(stall_timeout), 64'd1);
        check("wdog_stall_cycles", 64'(stall_cycles), 64'(exp_cycles));
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        check("wdog_reset_clears", 64'(stall_timeout), 64'd0);
        check("wdog_reset_cycles", 64'(stall_cycles), 64'd0);

        // Saturation of the stall-cycle counter.
        force dut.stall_cycles = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.stall_cycles;
        stallreq_ex = 1'b1;
        next_cycle();
        check("sat_first", 64'(stall_cycles), 64'hFFFF_FFFF);
        repeat (2) next_cycle();
        check("sat_hold", 64'(stall_cycles), 64'hFFFF_FFFF);
        stallreq_ex = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Merges stall requests from IF, ID, EX and MEM into the 6-bit stall vector consumed by PC/IF/ID/EX/MEM/WB.
- Sequences exception and ERET flushes: one flush pulse plus a PC redirect, then a masked recovery window.
- Keeps a stall-cycle counter and a stall watchdog for CP0 and debug.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect address for all exceptions except ERET.
- RECOVER_CYCLES, 2, cycles after a flush during which new exception requests are ignored (legal range 1..15).
- WDOG_LIMIT, 1024, consecutive stalled cycles before stall_timeout sets.

Ports:
- clk  in  1  core clock.
- rst  in  reset_status_t  synchronous, active-high reset (RST_ENABLE = 1).
- stallreq_if  in  1  instruction fetch not ready.
- stallreq_id  in  1  load-use hazard.
- stallreq_ex  in  1  multi-cycle EX operation (div/madd) busy.
- stallreq_mem  in  1  data access not ready.
- mem_excp  in  excp_t  {valid, is_eret, code[4:0]} from MEM.
- cp0_epc  in  inst_addr_t  EPC value used for ERET.
- stall  out  stall_t (6)  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- flush  out  1  clears IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- redirect  out  jump_t  {en, addr} to PC; highest priority over id_jumpreq.
- stall_cycles  out  32  saturating count of cycles with stall != 0.
- stall_timeout  out  1  sticky watchdog flag.

Behaviour:
- stall, flush and redirect are combinational from the inputs and the current state (zero latency). Counters and state are registered.
- Stall priority, highest first:
  - MEM → 6'b011111
  - EX → 6'b001111
  - ID → 6'b000111
  - IF → 6'b000011
  - none → 6'b000000
- States:
  - RUN: normal operation.
    - mem_excp.valid=1 → flush=1, stall=0 that cycle (flush overrides every stall request), redirect.en=1, next state RECOVER.
    - redirect.addr = cp0_epc if is_eret, else EXC_VECTOR.
  - RECOVER: holds RECOVER_CYCLES cycles.
    - flush=0, redirect.en=0; stall encoding operates normally.
    - mem_excp.valid is ignored.
    - 4-bit down-counter loads RECOVER_CYCLES-1 on entry; at 0 → RUN.
- Reset (rst=RST_ENABLE at a clk edge):
  - state=RUN, recover counter=0, stall_cycles=0, watchdog=0, stall_timeout=0.
  - While rst is high, outputs are forced: stall=0, flush=0, redirect.en=0, redirect.addr=0.
  - Reset mid-RECOVER abandons the recovery window immediately.
- stall_cycles: increments when stall != 0 and flush=0; saturates at 32'hFFFF_FFFF (no wrap).
- Watchdog:
  - Counts consecutive cycles with stall != 0 and clears on any non-stalled cycle.
  - When the count reaches WDOG_LIMIT, stall_timeout is set and stays set until reset.
  - The counter saturates at WDOG_LIMIT.
- Simultaneous exception and stall in RUN: the exception wins and the stall request is dropped for that cycle. The requester must re-assert it.
- Exception arriving in the last RECOVER cycle: ignored. MEM must keep valid asserted for it to be taken in RUN.

Decomposition:
- project_types package gains:
  - stall_t (logic [5:0]).
  - excp_t struct.
  - ctrl_state_t enum {CTRL_RUN, CTRL_RECOVER}.
  - Constants STALL_NONE, STALL_FROM_IF, STALL_FROM_ID, STALL_FROM_EX, STALL_FROM_MEM.
  - EXC_VECTOR_DEFAULT.
- jump_t and reset_status_t are reused unchanged.
- One sub-module, stall_watchdog: the consecutive-stall counter plus sticky flag, parameterised by WDOG_LIMIT.

Test Plan:
1. stallreq_id=1 and stallreq_ex=1 together, no exception → stall=6'b001111; drop ex → 6'b000111; drop id → 6'b000000. stall_cycles = 2 after these three cycles.
2. RUN, mem_excp={1,0,5'h04}, stallreq_mem=1 → same cycle: flush=1, stall=0, redirect={1,32'hBFC0_0380}. Next 2 cycles: flush=0 and a repeated mem_excp.valid is ignored. Third cycle: back in RUN.
3. ERET with cp0_epc=32'h8000_0100 → redirect.addr=32'h8000_0100, flush=1 for exactly one cycle.
4. stallreq_mem held 1024 cycles (WDOG_LIMIT=1024) → stall_timeout rises on the 1024th stalled cycle. Releasing the stall does not clear it; rst=1 clears it.
5. rst asserted in the first RECOVER cycle → next cycle state=RUN, all counters 0. An exception presented one cycle after rst deasserts is taken (flush=1).
6. Force stall_cycles to 32'hFFFF_FFFE, then stall 3 cycles → value holds at 32'hFFFF_FFFF.
